// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if -- request/grant bundle between the two mux clients and
// the mux_arbiter that owns the shared mux select line.
//
// Signals:
//   req  [1:0]  request per client (bit i = client i)
//   done [1:0]  one-cycle release pulse per client
//   gnt  [1:0]  one-hot registered grant, all-zero when idle
//   sel         registered mux select (index of current/last grantee)
//   busy        high whenever gnt is nonzero
//   lock        grantee lock request (only with MUX_ARB_LOCK_EN defined)
//
// Modports:
//   master -- the client side: drives req/done(/lock), observes the grant
//   slave  -- the arbiter side: observes requests, drives the grant
//
// Build option: MUX_ARB_LOCK_EN adds the lock signal.

interface mux_arbiter_if;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;

    modport master (output req, output done, output lock,
                    input gnt, input sel, input busy);
    modport slave  (input req, input done, input lock,
                    output gnt, output sel, output busy);
`else
    modport master (output req, output done,
                    input gnt, input sel, input busy);
    modport slave  (input req, input done,
                    output gnt, output sel, output busy);
`endif
endinterface : mux_arbiter_if

// File: rtl/mux_arbiter.sv
// mux_arbiter -- two-client round-robin arbiter owning the select line of a
// shared 2:1 mux. A grant is held until the grantee pulses done, drops its
// request, or has held the mux for HOLD_MAX cycles while the other client
// waits. Handoff to a waiting client happens on a single edge (no idle
// bubble). gnt, sel and busy are all registered.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux_arbiter_if (req, done, gnt, sel, busy,
//               and lock when MUX_ARB_LOCK_EN is defined)
//
// Parameters:
//   HOLD_MAX  max consecutive grant cycles under contention (1..255)
//   CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//
// Build option: MUX_ARB_LOCK_EN -- while lock is high the grantee cannot
// be preempted; done and request drop still release the grant.

module mux_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [CNT_W-1:0] PREEMPT_AT = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lp_q, lp_d;      // last-granted client
    logic [1:0]       gnt_q, gnt_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;

    logic owner;        // index of the current grantee (valid in G0/G1)
    logic other;
    logic locked;
    logic release_now;

`ifdef MUX_ARB_LOCK_EN
    assign locked = bus.lock;
`else
    assign locked = 1'b0;
`endif

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lp_q    <= 1'b1;   // client 0 wins the first tie
            gnt_q   <= 2'b00;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lp_q    <= lp_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        lp_d        = lp_q;
        owner       = (state_q == G1);
        other       = ~owner;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                case (bus.req)
                    2'b01:   state_d = G0;
                    2'b10:   state_d = G1;
                    2'b11:   state_d = lp_q ? G0 : G1;
                    default: state_d = IDLE;
                endcase
            end
            G0, G1: begin
                // The counter may sit at HOLD_MAX after an uncontended or
                // locked stretch; ">=" lets a newly waiting client take
                // over on the next edge instead of starving.
                release_now = bus.done[owner] | ~bus.req[owner] |
                              (bus.req[other] & ~locked & (cnt_q >= PREEMPT_AT));
                if (release_now) begin
                    lp_d    = owner;
                    cnt_d   = '0;
                    state_d = bus.req[other] ? (other ? G1 : G0) : IDLE;
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they change
        // exactly on the edge that enters it.
        gnt_d  = {state_d == G1, state_d == G0};
        busy_d = (state_d != IDLE);
        if (state_d == G1)      sel_d = 1'b1;
        else if (state_d == G0) sel_d = 1'b0;
        else                    sel_d = sel_q;   // hold last grantee in IDLE
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter -- self-checking bench for mux_arbiter: a directed vector
// table, hand-written multi-cycle sequences (preemption, long hold,
// asynchronous reset, lock) and randomized traffic compared against a
// cycle-count reference model. A second instance with HOLD_MAX=1 checks
// strict alternation.

module tb_mux_arbiter;

    localparam int HOLD_MAX = 8;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_arbiter_if bif ();
    mux_arbiter_if bif1 ();

    mux_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    mux_arbiter #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif1)
    );

    // Reference model: owner (-1 = idle), number of cycles the current
    // grant has been held (including the present one), last grantee.
    int m_owner;
    int m_cycles;
    int m_last;
    int m_sel;

    task automatic model_reset();
        m_owner  = -1;
        m_cycles = 0;
        m_last   = 1;
        m_sel    = 0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic [1:0] d, input logic l);
        int  i;
        int  j;
        bit  rel;
        bit  lk;
`ifdef MUX_ARB_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
        if (l) lk = 1'b0;
`endif
        if (m_owner < 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) m_owner = 1 - m_last;
                else            m_owner = (r == 2'b01) ? 0 : 1;
                m_cycles = 1;
                m_sel    = m_owner;
            end
        end else begin
            i   = m_owner;
            j   = 1 - i;
            rel = d[i] || !r[i] || (r[j] && !lk && m_cycles >= HOLD_MAX);
            if (rel) begin
                m_last = i;
                if (r[j]) begin
                    m_owner  = j;
                    m_cycles = 1;
                    m_sel    = j;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cycles++;
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one cycle, advance the model on the edge and
    // compare the registered outputs 1 time unit after it.
    task automatic step(input logic [1:0] r, input logic [1:0] d, input logic l);
        logic [1:0] exp_gnt;
        bif.req  = r;
        bif.done = d;
`ifdef MUX_ARB_LOCK_EN
        bif.lock = l;
`endif
        @(posedge clk);
        model_edge(r, d, l);
        #1;
        exp_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check("model_gnt",  {2'b00, bif.gnt},       {2'b00, exp_gnt});
        check("model_sel",  {3'b000, bif.sel},      4'(m_sel));
        check("model_busy", {3'b000, bif.busy},     {3'b000, m_owner >= 0});
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] done;
        logic [1:0] gnt;
        logic       sel;
        logic       busy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Directed table starting from reset (lp = 1).
        vecs[0]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b1}; // tie -> client 0
        vecs[1]  = '{2'b11, 2'b01, 2'b10, 1'b1, 1'b1}; // done0, direct handoff
        vecs[2]  = '{2'b11, 2'b10, 2'b01, 1'b0, 1'b1}; // done1, back to 0
        vecs[3]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b1}; // hold
        vecs[4]  = '{2'b01, 2'b10, 2'b01, 1'b0, 1'b1}; // done of non-grantee ignored
        vecs[5]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0}; // req drop -> idle, lp=0
        vecs[6]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b1}; // tie -> client 1
        vecs[7]  = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b0}; // done1, nobody waits
        vecs[8]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0}; // sel holds in idle
        vecs[9]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 2'b01, 2'b10, 1'b1, 1'b1}; // done0 + req0 fall = one release
        vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0};

        rst_n     = 1'b0;
        bif.req   = 2'b11;
        bif.done  = 2'b00;
        bif1.req  = 2'b11;
        bif1.done = 2'b00;
`ifdef MUX_ARB_LOCK_EN
        bif.lock  = 1'b0;
        bif1.lock = 1'b0;
`endif
        model_reset();

        // Reset state with requests already pending.
        repeat (2) @(negedge clk);
        check("rst_gnt",  {2'b00, bif.gnt},   4'h0);
        check("rst_sel",  {3'b000, bif.sel},  4'h0);
        check("rst_busy", {3'b000, bif.busy}, 4'h0);
        rst_n = 1'b1;

        // Table vectors; dut1 (HOLD_MAX=1, req=11) alternates meanwhile.
        for (int k = 0; k < 12; k++) begin
            step(vecs[k].req, vecs[k].done, 1'b0);
            check("vec_gnt",  {2'b00, bif.gnt},   {2'b00, vecs[k].gnt});
            check("vec_sel",  {3'b000, bif.sel},  {3'b000, vecs[k].sel});
            check("vec_busy", {3'b000, bif.busy}, {3'b000, vecs[k].busy});
            if (k < 6)
                check("alt_hold1", {2'b00, bif1.gnt}, (k % 2 == 0) ? 4'h1 : 4'h2);
        end

        // Preemption under constant contention: 8 cycles each.
        for (int k = 0; k < 24; k++) begin
            step(2'b11, 2'b00, 1'b0);
            check("preempt_gnt", {2'b00, bif.gnt}, ((k / HOLD_MAX) % 2 == 0) ? 4'h1 : 4'h2);
            check("preempt_sel", {3'b000, bif.sel}, 4'((k / HOLD_MAX) % 2));
        end

        // Long uncontended hold, then drop.
        for (int k = 0; k < 40; k++) begin
            step(2'b01, 2'b00, 1'b0);
            check("hold_gnt", {2'b00, bif.gnt}, 4'h1);
        end
        step(2'b00, 2'b00, 1'b0);
        check("drop_gnt",  {2'b00, bif.gnt},   4'h0);
        check("drop_busy", {3'b000, bif.busy}, 4'h0);
        check("drop_sel",  {3'b000, bif.sel},  4'h0);

        // Asynchronous reset in the middle of a G1 grant.
        step(2'b10, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        check("pre_rst_gnt", {2'b00, bif.gnt}, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt",  {2'b00, bif.gnt},   4'h0);
        check("async_sel",  {3'b000, bif.sel},  4'h0);
        check("async_busy", {3'b000, bif.busy}, 4'h0);
        model_reset();
        bif.req = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, 2'b00, 1'b0);
        check("post_rst_tie", {2'b00, bif.gnt}, 4'h1);

`ifdef MUX_ARB_LOCK_EN
        // Lock suppresses preemption; dropping it hands over at once.
        for (int k = 0; k < 20; k++) begin
            step(2'b11, 2'b00, 1'b1);
            check("lock_gnt", {2'b00, bif.gnt}, 4'h1);
        end
        step(2'b11, 2'b00, 1'b0);
        check("unlock_gnt", {2'b00, bif.gnt}, 4'h2);
`endif

        // Randomized traffic against the model; contention is frequent.
        for (int k = 0; k < 1500; k++) begin
            logic [1:0] r;
            logic [1:0] d;
            logic       l;
            r = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            d = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            l = ($urandom_range(0, 3) == 0);
            step(r, d, l);
            if (bif.gnt == 2'b11) check("gnt_onehot", {2'b00, bif.gnt}, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_arbiter
